// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 (x^16+x^12+x^5+1, init 0) frame checker. The last word of
// each data_valid burst is the transmitted CRC; it is recognised only when data_valid falls.
module crc16_frame_checker #(
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = $clog2(MAX_WORDS+2),
    parameter int ERR_W     = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [15:0]      data_in,
    input  logic             data_valid,
    input  logic             err_clr,
    output logic             check_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             len_err,
    output logic [CNT_W-1:0] frame_len,
    output logic [15:0]      calc_crc,
    output logic [ERR_W-1:0] err_cnt
);

    // One spare bit so the saturation value MAX_WORDS+2 always fits.
    localparam int CW = CNT_W + 1;
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_WORDS + 2);
    localparam logic [CW-1:0] LEN_MAX = CW'(MAX_WORDS + 1);

    typedef enum logic {IDLE, RECV} state_e;

    state_e           state_q, state_d;
    logic [15:0]      hold_q, hold_d;
    logic [15:0]      crc_q, crc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             lerr_q, lerr_d;
    logic [CNT_W-1:0] flen_q, flen_d;
    logic [15:0]      ccrc_q, ccrc_d;
    logic [ERR_W-1:0] ecnt_q, ecnt_d;
    logic             lerr_now;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] w);
        logic [15:0] t;
        t = c ^ w;
        for (int i = 0; i < 16; i++)
            t = t[15] ? ((t << 1) ^ 16'h1021) : (t << 1);
        return t;
    endfunction

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            lerr_q  <= 1'b0;
            flen_q  <= '0;
            ccrc_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            lerr_q  <= lerr_d;
            flen_q  <= flen_d;
            ccrc_q  <= ccrc_d;
            ecnt_q  <= ecnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        ok_d     = ok_q;
        err_d    = err_q;
        lerr_d   = lerr_q;
        flen_d   = flen_q;
        ccrc_d   = ccrc_q;
        lerr_now = 1'b0;
        // Clear first so a coinciding failure still counts once.
        ecnt_d   = err_clr ? '0 : ecnt_q;

        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    hold_d  = data_in;
                    crc_d   = '0;
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                if (data_valid) begin
                    // The held word is now known to be data, not the CRC.
                    crc_d  = crc_step(crc_q, hold_q);
                    hold_d = data_in;
                    if (cnt_q != CNT_SAT)
                        cnt_d = cnt_q + CW'(1);
                end else begin
                    lerr_now = (cnt_q < CW'(2)) || (cnt_q > LEN_MAX);
                    done_d   = 1'b1;
                    ccrc_d   = crc_q;
                    flen_d   = CNT_W'(cnt_q - CW'(1));
                    lerr_d   = lerr_now;
                    ok_d     = !lerr_now && (crc_q == hold_q);
                    err_d    = !ok_d;
                    if (!ok_d && (ecnt_d != '1))
                        ecnt_d = ecnt_d + ERR_W'(1);
                    crc_d    = '0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign check_done = done_q;
    assign crc_ok     = ok_q;
    assign crc_err    = err_q;
    assign len_err    = lerr_q;
    assign frame_len  = flen_q;
    assign calc_crc   = ccrc_q;
    assign err_cnt    = ecnt_q;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Directed bench for crc16_frame_checker (MAX_WORDS=4); inputs change and outputs
// are sampled on the falling clock edge.
module tb_crc16_frame_checker;

    localparam int MAXW  = 4;
    localparam int CNT_W = $clog2(MAXW+2);

    logic             clk_in = 1'b0;
    logic             rst;
    logic [15:0]      data_in;
    logic             data_valid;
    logic             err_clr;
    logic             check_done, crc_ok, crc_err, len_err;
    logic [CNT_W-1:0] frame_len;
    logic [15:0]      calc_crc;
    logic [7:0]       err_cnt;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          exp_err = 0;
    logic [15:0] fw [8];

    crc16_frame_checker #(.MAX_WORDS(MAXW), .CNT_W(CNT_W), .ERR_W(8)) dut (
        .clk_in(clk_in), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .err_clr(err_clr), .check_done(check_done), .crc_ok(crc_ok),
        .crc_err(crc_err), .len_err(len_err), .frame_len(frame_len),
        .calc_crc(calc_crc), .err_cnt(err_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drives fw[0..n-1], then one idle cycle; returns at the falling edge of the
    // check_done cycle, so the caller may start the next frame immediately.
    task automatic send_frame(input int n, input bit clr, input bit x_ok, input bit x_lerr,
                              input int x_flen, input logic [15:0] x_crc, input bit use_crc);
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b1;
            data_in    = fw[i];
            @(negedge clk_in);
        end
        chk("done_early", check_done, 1'b0);
        data_valid = 1'b0;
        data_in    = 16'h0;
        err_clr    = clr;
        @(negedge clk_in);
        err_clr = 1'b0;
        if (clr) exp_err = 0;
        if (!x_ok && exp_err != 255) exp_err++;
        chk("done", check_done, 1'b1);
        chk("crc_ok", crc_ok, x_ok);
        chk("crc_err", crc_err, !x_ok);
        chk("len_err", len_err, x_lerr);
        chk("frame_len", frame_len, x_flen);
        if (use_crc) chk("calc_crc", calc_crc, x_crc);
        chk("err_cnt", err_cnt, exp_err);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_done"}, check_done, 1'b0);
        chk({tag, "_ok"}, crc_ok, 1'b0);
        chk({tag, "_err"}, crc_err, 1'b0);
        chk({tag, "_lerr"}, len_err, 1'b0);
        chk({tag, "_flen"}, frame_len, 0);
        chk({tag, "_crc"}, calc_crc, 16'h0);
        chk({tag, "_ecnt"}, err_cnt, 8'h0);
    endtask

    initial begin
        rst = 1'b1; data_valid = 1'b0; data_in = 16'h0; err_clr = 1'b0;
        @(negedge clk_in); @(negedge clk_in);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk_in);

        // Good frame, then pulse must drop and status must hold.
        fw[0] = 16'h0001; fw[1] = 16'h1021;
        send_frame(2, 1'b0, 1'b1, 1'b0, 1, 16'h1021, 1'b1);
        @(negedge clk_in);
        chk("done_pulse", check_done, 1'b0);
        chk("ok_hold", crc_ok, 1'b1);

        // Corrupted CRC word.
        fw[0] = 16'h0001; fw[1] = 16'h1022;
        send_frame(2, 1'b0, 1'b0, 1'b0, 1, 16'h1021, 1'b1);

        // Back-to-back frames with one idle cycle between them.
        fw[0] = 16'h0002; fw[1] = 16'h2042;
        send_frame(2, 1'b0, 1'b1, 1'b0, 1, 16'h2042, 1'b1);
        fw[0] = 16'h0000; fw[1] = 16'h0000;
        send_frame(2, 1'b0, 1'b1, 1'b0, 1, 16'h0000, 1'b1);

        // Single-word frame: too short.
        fw[0] = 16'h1234;
        send_frame(1, 1'b0, 1'b0, 1'b1, 0, 16'h0000, 1'b1);

        // Six words with MAX_WORDS=4: oversize, length saturates at 5.
        for (int i = 0; i < 6; i++) fw[i] = 16'(16'h0100 + i);
        send_frame(6, 1'b0, 1'b0, 1'b1, 5, 16'h0000, 1'b0);

        // Idle cycles with data_valid low produce no evaluation.
        @(negedge clk_in); @(negedge clk_in);
        chk("idle_done", check_done, 1'b0);
        chk("lerr_hold", len_err, 1'b1);

        // Reset during the third word of a frame.
        data_valid = 1'b1; data_in = 16'h0001; @(negedge clk_in);
        data_in = 16'h0002; @(negedge clk_in);
        data_in = 16'h0003; rst = 1'b1; @(negedge clk_in);
        check_all_zero("midrst");
        rst = 1'b0; data_valid = 1'b0; data_in = 16'h0;
        exp_err = 0;
        @(negedge clk_in); @(negedge clk_in);
        chk("midrst_nodone", check_done, 1'b0);
        fw[0] = 16'h0001; fw[1] = 16'h1021;
        send_frame(2, 1'b0, 1'b1, 1'b0, 1, 16'h1021, 1'b1);

        // Saturate the error counter, then overflow attempt.
        fw[0] = 16'h0001; fw[1] = 16'h1022;
        for (int k = 0; k < 256; k++)
            send_frame(2, 1'b0, 1'b0, 1'b0, 1, 16'h1021, 1'b1);
        chk("err_sat", err_cnt, 8'hFF);

        // Clear coinciding with a failing evaluation leaves one error.
        send_frame(2, 1'b1, 1'b0, 1'b0, 1, 16'h1021, 1'b1);
        chk("clr_fail", err_cnt, 8'h01);

        // Stand-alone clear.
        err_clr = 1'b1; @(negedge clk_in);
        err_clr = 1'b0;
        chk("clr_only", err_cnt, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/crc16_frame_checker.md
Name: crc16_frame_checker

Overview:
- Receive-side counterpart of the team's CRC-16 generator.
- Accepts one frame as a contiguous burst of 16-bit words on `data_valid`. The last word of the burst is the transmitted CRC.
- Recomputes CRC-16 (x^16+x^12+x^5+1, init 0x0000) over the data words, compares it with the received CRC and reports pass/fail, frame length and a saturating error count.
- Sits between the deserialiser and the frame consumer.

Parameters:
- MAX_WORDS, 256, maximum data words per frame, excluding the CRC word; must be ≥1.
- CNT_W, $clog2(MAX_WORDS+2), width of the internal word counter and of `frame_len`.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk_in  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  16  frame word (data words, then CRC word).
- data_valid  input  1  high for every word of a frame; contiguous within a frame.
- err_clr  input  1  synchronous clear of `err_cnt`.
- check_done  output  1  one-cycle pulse: frame evaluated.
- crc_ok  output  1  last frame passed; valid from `check_done` until the next `check_done`.
- crc_err  output  1  last frame failed (CRC mismatch or length error).
- len_err  output  1  last frame had fewer than 2 words or more than MAX_WORDS+1 words.
- frame_len  output  CNT_W  data-word count of the last frame (total words − 1; 0 for a 1-word frame); saturates.
- calc_crc  output  16  CRC computed over the data words of the last frame.
- err_cnt  output  ERR_W  count of failed frames; saturates at all-ones.

Behaviour:
- Reset (async assert, sync deassert by the system): state IDLE, hold register cleared, crc=0, count=0, all outputs 0.
- CRC step, function step(c,w):
  - t = c ^ w;
  - repeat 16 times: t = t[15] ? (t<<1)^0x1021 : t<<1;
  - result = t.
  - MSB-first, no reflection, no final XOR.
  - Must be one combinational stage producing a result every cycle.
- Delayed accumulation via a one-word hold register, because the CRC word is identified only when `data_valid` falls:
  - IDLE, data_valid=1: hold<=data_in, crc<=0, count<=1, go RECV.
  - RECV, data_valid=1: crc<=step(crc,hold), hold<=data_in, count<=count+1 (saturate at MAX_WORDS+2).
  - RECV, data_valid=0 (evaluation edge): see next bullet; then crc<=0, count<=0, go IDLE.
- Evaluation registers, all updated on the evaluation edge:
  - check_done=1 for exactly one cycle;
  - calc_crc=crc;
  - frame_len=count−1;
  - len_err=(count<2)||(count>MAX_WORDS+1);
  - crc_ok=!len_err && (crc==hold);
  - crc_err=!crc_ok;
  - err_cnt+=1 if crc_err, unless saturated.
- Latency: `check_done` is high in the cycle after the first cycle `data_valid` is sampled low following a frame.
- Minimum inter-frame gap is 1 idle cycle. `data_valid` high in the cycle `check_done` is high starts a new frame normally.
- `data_valid` low in IDLE: no action; no `check_done`.
- Status outputs (`crc_ok`, `crc_err`, `len_err`, `frame_len`, `calc_crc`) hold their values between evaluations.
- `err_clr`:
  - Sets `err_cnt` to 0 on the next edge.
  - If it coincides with a failing evaluation, `err_cnt` becomes 1 (clear, then count).
- Oversize frame:
  - `count` saturates and CRC keeps accumulating.
  - At evaluation: `len_err`=1, `crc_ok`=0, `frame_len` = MAX_WORDS+1.
- Reset mid-frame: the partial frame is discarded, no `check_done`, outputs return to reset values.

Test Plan:
- Frame [0x0001,0x1021] → `check_done` pulse 1 cycle after `data_valid` falls; crc_ok=1, crc_err=0, len_err=0, frame_len=1, calc_crc=0x1021, err_cnt=0.
- Frame [0x0001,0x1022] → crc_ok=0, crc_err=1, calc_crc=0x1021, err_cnt=1.
- Back-to-back [0x0002,0x2042], 1-cycle gap, then [0x0000,0x0000] → two `check_done` pulses, both crc_ok=1; calc_crc 0x2042 then 0x0000.
- Single word [0x1234] → len_err=1, crc_err=1, frame_len=0, calc_crc=0x0000; err_cnt increments. MAX_WORDS=4 with a 6-word frame → len_err=1, frame_len=5.
- Assert rst during the 3rd word of a frame → no `check_done`, all outputs 0. Next frame [0x0001,0x1021] → crc_ok=1.
- Drive err_cnt to 0xFF with failing frames; another failure keeps 0xFF. err_clr together with a failing evaluation → err_cnt=1.
